// File: rtl/seg_disp_pkg.sv
// Shared types and helpers for the seven-segment display arbiter.
// Optional build macro LEADING_ZERO_BLANK_EN enables lz_mask use in the top.
package seg_disp_pkg;

   typedef enum logic [1:0] {
      LIVE  = 2'd0,
      EVENT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int DISP_MAX      = 9999;
   localparam int VAL_W_DEFAULT = 14;

   // Saturate a value to the four-digit display range.
   function automatic logic [13:0] clamp_val(input logic [31:0] v);
      if (v > 32'(DISP_MAX)) return 14'(DISP_MAX);
      return v[13:0];
   endfunction

   // Blank mask for leading-zero digits; the units digit always stays lit.
   function automatic logic [3:0] lz_mask(input logic [13:0] v);
      if (v >= 14'd1000) return 4'b0000;
      if (v >= 14'd100)  return 4'b1000;
      if (v >= 14'd10)   return 4'b1100;
      return 4'b1110;
   endfunction

endpackage

// File: rtl/seg_display_arbiter_timer.sv
// seg_tick_timer: tick prescaler plus tick down-counter.
// load clears the prescaler and loads the tick count; expire is high while the
// counter is on its final tick interval and must be qualified with tick.
module seg_tick_timer #(
   parameter int TICK_DIV = 4,
   parameter int CNT_W    = 8
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             tick,
   output logic             expire
);

   localparam int PRE_W = $clog2(TICK_DIV);

   logic [PRE_W-1:0] pre;
   logic [CNT_W-1:0] cnt;

   assign tick   = (pre == PRE_W'(TICK_DIV - 1));
   assign expire = (cnt == CNT_W'(1));

   // Prescaler wraps every TICK_DIV cycles; each wrap consumes one tick of the count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre <= '0;
         cnt <= '0;
      end else if (load) begin
         pre <= '0;
         cnt <= load_val;
      end else if (tick) begin
         pre <= '0;
         if (cnt != '0) cnt <= cnt - CNT_W'(1);
      end else begin
         pre <= pre + PRE_W'(1);
      end
   end

endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: shares the 4-digit display between a live value and
// held event values, with a one-deep event slot and a blank gap between events.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading-zero digits).
module seg_display_arbiter
   import seg_disp_pkg::*;
#(
   parameter int TICK_DIV   = 1000000,
   parameter int HOLD_TICKS = 200,
   parameter int GAP_TICKS  = 10,
   parameter int VAL_W      = VAL_W_DEFAULT
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [VAL_W-1:0] live_value,
   input  logic             ev_valid,
   input  logic [VAL_W-1:0] ev_value,
   output logic             ev_ready,
   input  logic             ev_flush,
   output logic [VAL_W-1:0] disp_value,
   output logic [3:0]       disp_blank,
   output logic             disp_src,
   output logic             busy
);

   localparam int CNT_MAX = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t           state, state_n;
   logic             pend_full, pend_full_n;
   logic [VAL_W-1:0] pend_val, pend_val_n;
   logic [VAL_W-1:0] disp_value_n;
   logic [3:0]       disp_blank_n;
   logic             xfer, tick, last, done;
   logic             load, enter_event;
   logic [CNT_W-1:0] load_val;
   logic [VAL_W-1:0] event_val;

   assign xfer = ev_valid & ev_ready;
   assign done = tick & last;

   seg_tick_timer #(
      .TICK_DIV (TICK_DIV),
      .CNT_W    (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .tick     (tick),
      .expire   (last)
   );

   // Next state, slot update, timer reload and next display contents.
   always_comb begin
      state_n      = state;
      pend_full_n  = pend_full;
      pend_val_n   = pend_val;
      load         = 1'b0;
      load_val     = '0;
      enter_event  = 1'b0;
      event_val    = ev_value;
      disp_value_n = disp_value;
      disp_blank_n = 4'b0000;

      if (ev_flush) begin
         state_n     = LIVE;
         pend_full_n = 1'b0;
      end else begin
         case (state)
            LIVE: begin
               // Accepted event bypasses the slot and goes straight on screen.
               if (xfer) begin
                  state_n     = EVENT;
                  enter_event = 1'b1;
                  event_val   = ev_value;
               end
            end
            EVENT: begin
               if (xfer) begin
                  pend_full_n = 1'b1;
                  pend_val_n  = ev_value;
               end
               // A transfer landing on the expiry edge already counts as pending.
               if (done) begin
                  if (pend_full_n) begin
                     if (GAP_TICKS == 0) begin
                        state_n     = EVENT;
                        enter_event = 1'b1;
                        event_val   = pend_val_n;
                        pend_full_n = 1'b0;
                     end else begin
                        state_n  = GAP;
                        load     = 1'b1;
                        load_val = CNT_W'(GAP_TICKS);
                     end
                  end else begin
                     state_n = LIVE;
                  end
               end
            end
            GAP: begin
               if (done) begin
                  state_n     = EVENT;
                  enter_event = 1'b1;
                  event_val   = pend_val;
                  pend_full_n = 1'b0;
               end
            end
            default: state_n = LIVE;
         endcase
      end

      if (enter_event) begin
         load     = 1'b1;
         load_val = CNT_W'(HOLD_TICKS);
      end
      // Timer is held cleared while live so every entry starts a fresh prescale.
      if (state_n == LIVE) load = 1'b1;

      if (state_n == LIVE)
         disp_value_n = VAL_W'(clamp_val(32'(live_value)));
      else if (enter_event)
         disp_value_n = VAL_W'(clamp_val(32'(event_val)));

      if (state_n == GAP)
         disp_blank_n = 4'b1111;
      else begin
`ifdef LEADING_ZERO_BLANK_EN
         disp_blank_n = lz_mask(14'(disp_value_n));
`else
         disp_blank_n = 4'b0000;
`endif
      end
   end

   // Control state and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= LIVE;
         pend_full  <= 1'b0;
         ev_ready   <= 1'b1;
         disp_value <= '0;
         disp_blank <= 4'b0000;
         disp_src   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         pend_full  <= pend_full_n;
         ev_ready   <= !pend_full_n;
         disp_value <= disp_value_n;
         disp_blank <= disp_blank_n;
         disp_src   <= (state_n != LIVE);
         busy       <= (state_n != LIVE);
      end
   end

   // Pending event payload; only meaningful while pend_full is set.
   always_ff @(posedge clk) begin
      pend_val <= pend_val_n;
   end

endmodule
